hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 SHALL have parameter MAX_OUT, default 4, meaning the maximum number of outstanding register writes (range 1..7).
REQ-002 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port id_valid, input, 1 bit: the decode stage holds an instruction.
REQ-005 SHALL have ports id_rs and id_rt, input, 5 bits each: source register indices from instr[25:21] and instr[20:16].
REQ-006 SHALL have ports id_uses_rs and id_uses_rt, input, 1 bit each: the matching source is actually read.
REQ-007 SHALL have port id_dest, input, 5 bits: destination index (rt or rd, already muxed by the RegDst choice).
REQ-008 SHALL have port id_reg_write, input, 1 bit: the instruction writes id_dest.
REQ-009 SHALL have port flush, input, 1 bit: squash the decode instruction this cycle (taken branch or jump).
REQ-010 SHALL have ports wb_valid (input, 1 bit) and wb_reg (input, 5 bits): a writeback completes to wb_reg this cycle.
REQ-011 SHALL have ports drain_req (input, 1 bit) and drain_done (output, 1 bit): pipeline drain handshake.
REQ-012 SHALL have port issue, output, 1 bit: the instruction leaves decode this cycle.
REQ-013 SHALL have port stall, output, 1 bit: id_valid is high, flush is low, and issue is low.
REQ-014 SHALL have port busy, output, 32 bits: per-register pending-write vector.
REQ-015 SHALL have port outstanding, output, 3 bits: count of in-flight writes.
REQ-016 SHALL have ports wb_err (output, 1 bit, sticky) and stall_cnt (output, 16 bits, saturating count of stall cycles).

Function
REQ-017 SHALL define effective busy for hazard checks as busy with the bit for wb_reg cleared when wb_valid is high (same-cycle writeback bypass).
REQ-018 SHALL flag a RAW hazard when id_uses_rs is high and effective busy[id_rs] is set, or when id_uses_rt is high and effective busy[id_rt] is set.
REQ-019 SHALL flag a WAW hazard when id_reg_write is high, id_dest is not 0, and effective busy[id_dest] is set.
REQ-020 SHALL flag a capacity hazard when id_reg_write is high, id_dest is not 0, outstanding equals MAX_OUT, and no writeback occurs this cycle.
REQ-021 SHALL assert issue combinationally when id_valid is high, flush is low, state is RUN, and there is no RAW, WAW or capacity hazard.
REQ-022 SHALL, on issue with id_reg_write high and id_dest not 0, set busy[id_dest] and increment outstanding at the next edge.
REQ-023 SHALL, on a writeback to a busy register other than 0, clear that busy bit and decrement outstanding.
REQ-024 SHALL let a set win over a clear when issue and writeback target the same register in the same cycle (busy stays 1, outstanding unchanged).
REQ-025 SHALL never set busy[0], SHALL never stall on register 0, and SHALL ignore writebacks to register 0.
REQ-026 SHALL, on a writeback to a non-busy register other than 0, leave busy and outstanding unchanged and set wb_err until reset.
REQ-027 SHALL increment stall_cnt on every stall cycle and saturate it at 0xFFFF.
REQ-028 SHALL give flush priority over issue: nothing is issued or recorded, and the cycle is not counted as a stall.
REQ-029 SHALL implement an FSM with states RUN, DRAIN and DONE:
- RUN to DRAIN when drain_req is high.
- DRAIN to DONE when outstanding is 0, including the same cycle the last writeback lands.
- DONE to RUN when drain_req is low.
REQ-030 SHALL block issue in DRAIN and DONE while still processing writebacks, and SHALL assert drain_done only in DONE.

Reset
REQ-031 SHALL, on rst high at a clock edge, set busy to 0, outstanding to 0, wb_err to 0, stall_cnt to 0 and the state to RUN, overriding any same-cycle issue or writeback.
REQ-032 SHALL drive issue, stall and drain_done low during any cycle in which rst is high.

Structure
REQ-033 SHALL place the FSM state encoding and the REG_ZERO constant (5'd0) in a shared package hazard_pkg.
REQ-034 SHALL implement the hazard and issue logic in a single sub-module hazard_check (combinational: effective busy plus hazard flags), with the sequential state held in hazard_scoreboard.

Verification
REQ-035 SHALL cover RAW stall: issue a write to r8, then present a read of rs=8 -> stall=1 until wb_reg=8; issue occurs in the wb cycle; stall_cnt equals the stall cycles.
REQ-036 SHALL cover same-cycle writeback and reissue: busy[5]=1, wb_reg=5 together with an issue writing r5 -> busy[5]=1 next cycle, outstanding unchanged.
REQ-037 SHALL cover capacity: 4 writes to r1..r4 -> outstanding=4, a 5th write stalls, a read-only instruction still issues.
REQ-038 SHALL cover the drain handshake: drain_req with outstanding=2 -> issue=0, drain_done rises the cycle after the 2nd writeback, and returns to RUN after drain_req drops.
REQ-039 SHALL cover error and edge cases: wb_reg=9 while not busy -> wb_err=1 and sticky; a write to r0 -> busy stays 0; flush with a hazard -> stall=0.
REQ-040 SHALL cover reset mid-operation: busy nonzero and state DRAIN, assert rst -> all outputs 0 and state RUN on the next cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the decode-stage register hazard scoreboard.
// Holds the drain FSM encoding and the hard-wired zero register index.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_check.sv
// Combinational hazard detection: writeback-bypassed busy vector, RAW/WAW/capacity
// flags, and the resulting issue/stall decision for the decode instruction.
module hazard_check
    import hazard_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic        rst,
    input  logic        run,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_dest,
    input  logic        id_reg_write,
    input  logic        flush,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] busy,
    input  logic [2:0]  outstanding,
    output logic        wb_retire,
    output logic        set_busy,
    output logic        issue,
    output logic        stall
);

    localparam logic [2:0] OUT_LIMIT = 3'(MAX_OUT);

    logic [31:0] eff_busy;
    logic        dest_live;
    logic        raw_haz;
    logic        waw_haz;
    logic        cap_haz;

    // A register completing writeback this cycle is already readable (bypass).
    always_comb begin
        eff_busy = busy;
        if (wb_valid) begin
            eff_busy[wb_reg] = 1'b0;
        end
        eff_busy[REG_ZERO] = 1'b0;
    end

    assign dest_live = id_reg_write && (id_dest != REG_ZERO);
    assign wb_retire = wb_valid && (wb_reg != REG_ZERO) && busy[wb_reg];

    assign raw_haz = (id_uses_rs && eff_busy[id_rs]) || (id_uses_rt && eff_busy[id_rt]);
    assign waw_haz = dest_live && eff_busy[id_dest];
    // A retiring writeback frees a slot in the same cycle, so capacity is not hit.
    assign cap_haz = dest_live && (outstanding == OUT_LIMIT) && !wb_retire;

    assign issue    = id_valid && !flush && run && !rst && !raw_haz && !waw_haz && !cap_haz;
    assign stall    = id_valid && !flush && !rst && !issue;
    assign set_busy = issue && dest_live;

endmodule

// File: rtl/hazard_scoreboard.sv
// Register write scoreboard: tracks pending writes, counts stalls, flags stray
// writebacks and runs the RUN/DRAIN/DONE pipeline drain handshake.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int MAX_OUT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_dest,
    input  logic        id_reg_write,
    input  logic        flush,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    input  logic        drain_req,
    output logic        drain_done,
    output logic        issue,
    output logic        stall,
    output logic [31:0] busy,
    output logic [2:0]  outstanding,
    output logic        wb_err,
    output logic [15:0] stall_cnt
);

    state_e      state_q, state_d;
    logic [31:0] busy_q, busy_d;
    logic [2:0]  out_q, out_d;
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
    logic        wb_retire;
    logic        set_busy;

    hazard_check #(
        .MAX_OUT (MAX_OUT)
    ) u_check (
        .rst          (rst),
        .run          (state_q == ST_RUN),
        .id_valid     (id_valid),
        .id_rs        (id_rs),
        .id_rt        (id_rt),
        .id_uses_rs   (id_uses_rs),
        .id_uses_rt   (id_uses_rt),
        .id_dest      (id_dest),
        .id_reg_write (id_reg_write),
        .flush        (flush),
        .wb_valid     (wb_valid),
        .wb_reg       (wb_reg),
        .busy         (busy_q),
        .outstanding  (out_q),
        .wb_retire    (wb_retire),
        .set_busy     (set_busy),
        .issue        (issue),
        .stall        (stall)
    );

    // Clear is applied before set so a same-cycle reissue keeps the bit busy.
    always_comb begin
        busy_d = busy_q;
        if (wb_retire) begin
            busy_d[wb_reg] = 1'b0;
        end
        if (set_busy) begin
            busy_d[id_dest] = 1'b1;
        end
        out_d = out_q + {2'b00, set_busy} - {2'b00, wb_retire};
        err_d = err_q || (wb_valid && (wb_reg != REG_ZERO) && !busy_q[wb_reg]);
        cnt_d = (stall && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;

        state_d = state_q;
        unique case (state_q)
            ST_RUN:   if (drain_req)      state_d = ST_DRAIN;
            ST_DRAIN: if (out_d == 3'd0)  state_d = ST_DONE;
            ST_DONE:  if (!drain_req)     state_d = ST_RUN;
            default:                      state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            busy_q  <= 32'd0;
            out_q   <= 3'd0;
            err_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            out_q   <= out_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign drain_done  = (state_q == ST_DONE) && !rst;
    assign busy        = busy_q;
    assign outstanding = out_q;
    assign wb_err      = err_q;
    assign stall_cnt   = cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios followed by random
// traffic, all compared against a pending-register-set model of the scoreboard.
module tb_hazard_scoreboard;

    localparam int MAX_OUT = 4;
    localparam int M_RUN   = 0;
    localparam int M_DRAIN = 1;
    localparam int M_DONE  = 2;

    typedef struct {
        logic       v;
        logic [4:0] rs;
        logic       urs;
        logic [4:0] rt;
        logic       urt;
        logic [4:0] dest;
        logic       rw;
        logic       fl;
        logic       wbv;
        logic [4:0] wbr;
        logic       dr;
        logic       r;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        idValid = 1'b0;
    logic [4:0]  idRs = 5'd0;
    logic [4:0]  idRt = 5'd0;
    logic        idUsesRs = 1'b0;
    logic        idUsesRt = 1'b0;
    logic [4:0]  idDest = 5'd0;
    logic        idRegWrite = 1'b0;
    logic        flushIn = 1'b0;
    logic        wbValid = 1'b0;
    logic [4:0]  wbReg = 5'd0;
    logic        drainReq = 1'b0;
    logic        drainDone;
    logic        issueOut;
    logic        stallOut;
    logic [31:0] busyOut;
    logic [2:0]  outstandingOut;
    logic        wbErr;
    logic [15:0] stallCnt;

    bit pend [32];
    int mode;
    bit errM;
    int stallsM;
    int nChecks = 0;
    int nFails  = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (idValid),
        .id_rs        (idRs),
        .id_rt        (idRt),
        .id_uses_rs   (idUsesRs),
        .id_uses_rt   (idUsesRt),
        .id_dest      (idDest),
        .id_reg_write (idRegWrite),
        .flush        (flushIn),
        .wb_valid     (wbValid),
        .wb_reg       (wbReg),
        .drain_req    (drainReq),
        .drain_done   (drainDone),
        .issue        (issueOut),
        .stall        (stallOut),
        .busy         (busyOut),
        .outstanding  (outstandingOut),
        .wb_err       (wbErr),
        .stall_cnt    (stallCnt)
    );

    // Argument order: valid, rs, uses_rs, rt, uses_rt, dest, reg_write, flush, wb_valid, wb_reg, drain_req, rst
    function automatic stim_t mk(input logic v, input logic [4:0] rs, input logic urs,
                                 input logic [4:0] rt, input logic urt, input logic [4:0] dest,
                                 input logic rw, input logic fl, input logic wbv,
                                 input logic [4:0] wbr, input logic dr, input logic r);
        stim_t s;
        s.v = v; s.rs = rs; s.urs = urs; s.rt = rt; s.urt = urt; s.dest = dest;
        s.rw = rw; s.fl = fl; s.wbv = wbv; s.wbr = wbr; s.dr = dr; s.r = r;
        return s;
    endfunction

    function automatic int countPending();
        int c = 0;
        for (int i = 1; i < 32; i++) c += int'(pend[i]);
        return c;
    endfunction

    function automatic logic [31:0] pendVec();
        logic [31:0] vec = 32'd0;
        for (int i = 1; i < 32; i++) vec[i] = pend[i];
        return vec;
    endfunction

    // An instruction may leave decode only if nothing it touches is still owed a write.
    function automatic bit modelIssue(input stim_t s);
        bit blocked;
        bit freed;
        bit writesReg;
        freed     = s.wbv && (s.wbr != 5'd0) && pend[s.wbr];
        writesReg = s.rw && (s.dest != 5'd0);
        blocked   = 1'b0;
        if (s.urs && s.rs != 5'd0 && pend[s.rs] && !(s.wbv && s.wbr == s.rs)) blocked = 1'b1;
        if (s.urt && s.rt != 5'd0 && pend[s.rt] && !(s.wbv && s.wbr == s.rt)) blocked = 1'b1;
        if (writesReg && pend[s.dest] && !(s.wbv && s.wbr == s.dest)) blocked = 1'b1;
        if (writesReg && countPending() == MAX_OUT && !freed) blocked = 1'b1;
        return s.v && !s.fl && !s.r && (mode == M_RUN) && !blocked;
    endfunction

    task automatic applyStimulus(input stim_t s);
        idValid = s.v; idRs = s.rs; idUsesRs = s.urs; idRt = s.rt; idUsesRt = s.urt;
        idDest = s.dest; idRegWrite = s.rw; flushIn = s.fl; wbValid = s.wbv; wbReg = s.wbr;
        drainReq = s.dr; rst = s.r;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic runCycle(input stim_t s, input string tag);
        bit expIssue;
        bit expStall;
        bit retire;
        applyStimulus(s);
        #2;
        expIssue = modelIssue(s);
        expStall = s.v && !s.fl && !s.r && !expIssue;
        checkOutput({tag, ".issue"}, 32'(issueOut), 32'(expIssue));
        checkOutput({tag, ".stall"}, 32'(stallOut), 32'(expStall));
        checkOutput({tag, ".drain_done"}, 32'(drainDone), 32'(mode == M_DONE && !s.r));
        checkOutput({tag, ".busy"}, busyOut, pendVec());
        checkOutput({tag, ".outstanding"}, 32'(outstandingOut), 32'(countPending()));
        checkOutput({tag, ".wb_err"}, 32'(wbErr), 32'(errM));
        checkOutput({tag, ".stall_cnt"}, 32'(stallCnt), 32'(stallsM));
        if (s.r) begin
            foreach (pend[i]) pend[i] = 1'b0;
            mode = M_RUN; errM = 1'b0; stallsM = 0;
        end else begin
            retire = s.wbv && (s.wbr != 5'd0) && pend[s.wbr];
            if (s.wbv && s.wbr != 5'd0 && !pend[s.wbr]) errM = 1'b1;
            if (retire) pend[s.wbr] = 1'b0;
            if (expIssue && s.rw && s.dest != 5'd0) pend[s.dest] = 1'b1;
            if (expStall && stallsM < 65535) stallsM++;
            case (mode)
                M_RUN:   if (s.dr) mode = M_DRAIN;
                M_DRAIN: if (countPending() == 0) mode = M_DONE;
                default: if (!s.dr) mode = M_RUN;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        stim_t s;
        int prevCnt;
        int pickQ [$];
        foreach (pend[i]) pend[i] = 1'b0;
        mode = M_RUN; errM = 1'b0; stallsM = 0;

        // First reset cycle: registers are still unknown, only the rst-gated outputs are defined.
        applyStimulus(mk(1, 0, 0, 0, 0, 5'd3, 1, 0, 0, 0, 0, 1));
        #2;
        checkOutput("rst0.issue", 32'(issueOut), 32'd0);
        checkOutput("rst0.stall", 32'(stallOut), 32'd0);
        checkOutput("rst0.drain_done", 32'(drainDone), 32'd0);
        @(posedge clk);
        #1;
        runCycle(mk(1, 0, 0, 0, 0, 5'd3, 1, 0, 0, 0, 0, 1), "rst1");
        checkOutput("post_rst.busy", busyOut, 32'd0);

        // RAW on r8: three stall cycles, then issue in the writeback cycle.
        runCycle(mk(1, 0, 0, 0, 0, 5'd8, 1, 0, 0, 0, 0, 0), "raw_w8");
        for (int i = 0; i < 3; i++) runCycle(mk(1, 5'd8, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "raw_stall");
        runCycle(mk(1, 5'd8, 1, 0, 0, 0, 0, 0, 1, 5'd8, 0, 0), "raw_wb");
        checkOutput("raw.stall_cnt", 32'(stallCnt), 32'd3);
        checkOutput("raw.busy", busyOut, 32'd0);

        // Same-cycle writeback of r5 and reissue of a write to r5.
        runCycle(mk(1, 0, 0, 0, 0, 5'd5, 1, 0, 0, 0, 0, 0), "rew_w5");
        runCycle(mk(1, 0, 0, 0, 0, 5'd5, 1, 0, 1, 5'd5, 0, 0), "rew_both");
        checkOutput("rew.busy5", 32'(busyOut[5]), 32'd1);
        checkOutput("rew.outstanding", 32'(outstandingOut), 32'd1);
        runCycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd5, 0, 0), "rew_wb");

        // Capacity: four writes fill the table, a fifth stalls, a pure read still issues.
        for (int i = 1; i <= 4; i++) runCycle(mk(1, 0, 0, 0, 0, 5'(i), 1, 0, 0, 0, 0, 0), "cap_w");
        checkOutput("cap.outstanding", 32'(outstandingOut), 32'd4);
        prevCnt = int'(stallCnt);
        runCycle(mk(1, 0, 0, 0, 0, 5'd6, 1, 0, 0, 0, 0, 0), "cap_5th");
        checkOutput("cap.5th_stalled", 32'(stallCnt), 32'(prevCnt + 1));
        checkOutput("cap.busy6", 32'(busyOut[6]), 32'd0);
        runCycle(mk(1, 5'd7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "cap_read");
        for (int i = 1; i <= 4; i++) runCycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'(i), 0, 0), "cap_wb");

        // Drain handshake with two writes in flight.
        runCycle(mk(1, 0, 0, 0, 0, 5'd10, 1, 0, 0, 0, 0, 0), "drn_w10");
        runCycle(mk(1, 0, 0, 0, 0, 5'd11, 1, 0, 0, 0, 0, 0), "drn_w11");
        runCycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "drn_req");
        runCycle(mk(1, 5'd3, 1, 0, 0, 0, 0, 0, 1, 5'd10, 1, 0), "drn_wb10");
        checkOutput("drn.done_early", 32'(drainDone), 32'd0);
        runCycle(mk(1, 5'd3, 1, 0, 0, 0, 0, 0, 1, 5'd11, 1, 0), "drn_wb11");
        checkOutput("drn.done", 32'(drainDone), 32'd1);
        runCycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "drn_hold");
        runCycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "drn_release");
        checkOutput("drn.released", 32'(drainDone), 32'd0);
        runCycle(mk(1, 5'd3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "drn_resume");

        // Stray writeback, write to r0, and flush over a hazard.
        runCycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd9, 0, 0), "err_wb9");
        checkOutput("err.set", 32'(wbErr), 32'd1);
        runCycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0), "err_idle");
        checkOutput("err.sticky", 32'(wbErr), 32'd1);
        runCycle(mk(1, 0, 0, 0, 0, 5'd0, 1, 0, 0, 0, 0, 0), "r0_write");
        checkOutput("r0.busy", busyOut, 32'd0);
        runCycle(mk(1, 0, 0, 0, 0, 5'd12, 1, 0, 0, 0, 0, 0), "fl_w12");
        prevCnt = int'(stallCnt);
        runCycle(mk(1, 5'd12, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0), "fl_hazard");
        checkOutput("fl.no_stall_count", 32'(stallCnt), 32'(prevCnt));
        runCycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 5'd12, 0, 0), "fl_wb12");

        // Reset while draining with a write still pending.
        runCycle(mk(1, 0, 0, 0, 0, 5'd13, 1, 0, 0, 0, 0, 0), "mr_w13");
        runCycle(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), "mr_drain");
        runCycle(mk(1, 5'd2, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1), "mr_rst");
        checkOutput("mr.busy", busyOut, 32'd0);
        checkOutput("mr.outstanding", 32'(outstandingOut), 32'd0);
        checkOutput("mr.wb_err", 32'(wbErr), 32'd0);
        checkOutput("mr.stall_cnt", 32'(stallCnt), 32'd0);
        runCycle(mk(1, 5'd2, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0), "mr_run");

        // Random traffic; writebacks only ever target registers the model holds pending.
        for (int n = 0; n < 400; n++) begin
            s = mk($urandom_range(0, 3) != 0, 5'($urandom), 1'($urandom), 5'($urandom), 1'($urandom),
                   5'($urandom_range(0, 15)), 1'($urandom), $urandom_range(0, 7) == 0, 0, 0,
                   $urandom_range(0, 19) == 0, $urandom_range(0, 79) == 0);
            pickQ.delete();
            for (int i = 1; i < 32; i++) if (pend[i]) pickQ.push_back(i);
            if (pickQ.size() > 0 && $urandom_range(0, 1) == 1) begin
                s.wbv = 1'b1;
                s.wbr = 5'(pickQ[$urandom_range(0, pickQ.size() - 1)]);
            end
            runCycle(s, $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
